// File: rtl/branch_resolver_if.sv
// Handshake and result bundle between fetch/decode (master) and the branch resolver (slave).
interface branch_resolver_if;
  logic        pred_valid;
  logic [63:0] pred_pc;
  logic [63:0] pred_target;
  logic        pred_ready;
  logic        res_valid;
  logic        res_taken;
  logic [63:0] res_target;
  logic        res_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;

  modport master (
    output pred_valid, pred_pc, pred_target, res_valid, res_taken, res_target,
    input  pred_ready, res_ready, redirect_valid, redirect_pc, flush,
           upd_valid, upd_pc, upd_taken
  );

  modport slave (
    input  pred_valid, pred_pc, pred_target, res_valid, res_taken, res_target,
    output pred_ready, res_ready, redirect_valid, redirect_pc, flush,
           upd_valid, upd_pc, upd_taken
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: in-order queue of fetch-time predictions checked against ID-stage
// resolutions, producing redirect/flush, predictor training pulses and statistics.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  branch_resolver_if.slave   bus,
  output logic [OCC_W-1:0]   occupancy,
  output logic [CNT_W-1:0]   branch_count,
  output logic [CNT_W-1:0]   mispredict_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == {CNT_W{1'b1}}) begin
      return val;
    end else begin
      return val + CNT_W'(1'b1);
    end
  endfunction

  logic [63:0]      pc_mem_r  [DEPTH];
  logic [63:0]      tgt_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [OCC_W-1:0] count_r;

  logic [PTR_W-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [OCC_W-1:0] count_nxt_s;
  logic             pred_ready_s, res_ready_s;
  logic             push_s, pop_s, mispredict_s;
  logic [63:0]      head_pc_s, head_tgt_s, correct_pc_s;

  logic             redirect_valid_r, upd_valid_r, upd_taken_r;
  logic [63:0]      redirect_pc_r, upd_pc_r;
  logic [CNT_W-1:0] branch_cnt_r, mispred_cnt_r;

  assign pred_ready_s         = (count_r < OCC_W'(DEPTH));
  assign res_ready_s          = (count_r != {OCC_W{1'b0}});
  assign bus.pred_ready       = pred_ready_s;
  assign bus.res_ready        = res_ready_s;
  assign bus.redirect_valid   = redirect_valid_r;
  assign bus.flush            = redirect_valid_r;
  assign bus.redirect_pc      = redirect_pc_r;
  assign bus.upd_valid        = upd_valid_r;
  assign bus.upd_pc           = upd_pc_r;
  assign bus.upd_taken        = upd_taken_r;
  assign occupancy            = count_r;
  assign branch_count         = branch_cnt_r;
  assign mispredict_count     = mispred_cnt_r;

  // Accept decisions and comparison of the true next PC against the head prediction
  always_comb begin
    push_s     = bus.pred_valid & pred_ready_s;
    pop_s      = bus.res_valid & res_ready_s;
    head_pc_s  = pc_mem_r[rd_ptr_r];
    head_tgt_s = tgt_mem_r[rd_ptr_r];
    if (bus.res_taken) begin
      correct_pc_s = bus.res_target;
    end else begin
      correct_pc_s = head_pc_s + 64'd4;
    end
    mispredict_s = pop_s & (correct_pc_s != head_tgt_s);
  end

  // Queue pointer/count update; a mispredict discards everything including a same-cycle push
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (mispredict_s) begin
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      count_nxt_s  = {OCC_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1'b1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + OCC_W'(1'b1);
        2'b01:   count_nxt_s = count_r - OCC_W'(1'b1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (!rst && push_s && !mispredict_s) begin
      pc_mem_r[wr_ptr_r]  <= bus.pred_pc;
      tgt_mem_r[wr_ptr_r] <= bus.pred_target;
    end
  end

  // Queue state, single-cycle pulses and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r         <= {PTR_W{1'b0}};
      rd_ptr_r         <= {PTR_W{1'b0}};
      count_r          <= {OCC_W{1'b0}};
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 64'd0;
      upd_valid_r      <= 1'b0;
      upd_pc_r         <= 64'd0;
      upd_taken_r      <= 1'b0;
      branch_cnt_r     <= {CNT_W{1'b0}};
      mispred_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r         <= wr_ptr_nxt_s;
      rd_ptr_r         <= rd_ptr_nxt_s;
      count_r          <= count_nxt_s;
      redirect_valid_r <= mispredict_s;
      upd_valid_r      <= pop_s;
      if (mispredict_s) begin
        redirect_pc_r <= correct_pc_s;
        mispred_cnt_r <= sat_inc(mispred_cnt_r);
      end
      if (pop_s) begin
        upd_pc_r     <= head_pc_s;
        upd_taken_r  <= bus.res_taken;
        branch_cnt_r <= sat_inc(branch_cnt_r);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a behavioural queue model predicts each resolution,
// expected updates are queued at drive time and compared when the DUT pulses.
module tb_branch_resolver;
  localparam int DEPTH = 4;
  localparam int CW    = 4;   // narrow counters so saturation is reachable

  typedef struct { logic [63:0] pc; logic [63:0] tgt; } ent_t;
  typedef struct { logic [63:0] pc; logic taken; logic mis; logic [63:0] cpc; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic [CW-1:0] branch_count, mispredict_count;

  branch_resolver_if bus ();

  branch_resolver #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .occupancy(occupancy), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  ent_t mq[$];
  exp_t sb[$];
  logic [CW-1:0] m_bc, m_mc;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Post-edge comparison of everything the model knows about
  task automatic check_outputs();
    exp_t e;
    logic exp_u;
    exp_u = (sb.size() != 0);
    check_eq("upd_valid", bus.upd_valid, exp_u);
    if (exp_u) begin
      e = sb.pop_front();
      check_eq("upd_pc", bus.upd_pc, e.pc);
      check_eq("upd_taken", bus.upd_taken, e.taken);
      check_eq("redirect_valid", bus.redirect_valid, e.mis);
      check_eq("flush", bus.flush, e.mis);
      if (e.mis) check_eq("redirect_pc", bus.redirect_pc, e.cpc);
    end else begin
      check_eq("redirect_valid_idle", bus.redirect_valid, 1'b0);
    end
    check_eq("occupancy", occupancy, mq.size());
    check_eq("branch_count", branch_count, m_bc);
    check_eq("mispredict_count", mispredict_count, m_mc);
  endtask

  task automatic step(input logic pv, input logic [63:0] ppc, input logic [63:0] ptgt,
                      input logic rv, input logic rt, input logic [63:0] rtgt);
    logic rdy_p, rdy_r, acc_p, acc_r, mis;
    logic [63:0] cpc;
    ent_t h, n;
    exp_t e;
    bus.pred_valid = pv; bus.pred_pc = ppc; bus.pred_target = ptgt;
    bus.res_valid = rv; bus.res_taken = rt; bus.res_target = rtgt;
    rdy_p = (mq.size() < DEPTH);
    rdy_r = (mq.size() > 0);
    #1;
    check_eq("pred_ready", bus.pred_ready, rdy_p);
    check_eq("res_ready", bus.res_ready, rdy_r);
    acc_p = pv && rdy_p;
    acc_r = rv && rdy_r;
    mis = 1'b0;
    if (acc_r) begin
      h   = mq[0];
      cpc = rt ? rtgt : h.pc + 64'd4;
      mis = (cpc != h.tgt);
      e.pc = h.pc; e.taken = rt; e.mis = mis; e.cpc = cpc;
      sb.push_back(e);
      if (m_bc != {CW{1'b1}}) m_bc = m_bc + 1'b1;
      if (mis && m_mc != {CW{1'b1}}) m_mc = m_mc + 1'b1;
    end
    if (mis) mq.delete();
    else begin
      if (acc_r) void'(mq.pop_front());
      if (acc_p) begin n.pc = ppc; n.tgt = ptgt; mq.push_back(n); end
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic push(input logic [63:0] pc, input logic [63:0] tgt);
    step(1'b1, pc, tgt, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic resolve(input logic rt, input logic [63:0] rtgt);
    step(1'b0, 64'd0, 64'd0, 1'b1, rt, rtgt);
  endtask

  // Reset with traffic driven: that traffic must be ignored and all outputs cleared
  task automatic do_reset();
    rst = 1'b1;
    bus.pred_valid = 1'b1; bus.pred_pc = 64'hDEAD_0000; bus.pred_target = 64'hDEAD_0004;
    bus.res_valid = 1'b1; bus.res_taken = 1'b1; bus.res_target = 64'hBAD0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.pred_valid = 1'b0; bus.res_valid = 1'b0;
    mq.delete(); sb.delete(); m_bc = '0; m_mc = '0;
    check_eq("rst_redirect_valid", bus.redirect_valid, 1'b0);
    check_eq("rst_flush", bus.flush, 1'b0);
    check_eq("rst_redirect_pc", bus.redirect_pc, 64'd0);
    check_eq("rst_upd_valid", bus.upd_valid, 1'b0);
    check_eq("rst_upd_pc", bus.upd_pc, 64'd0);
    check_eq("rst_upd_taken", bus.upd_taken, 1'b0);
    check_eq("rst_occupancy", occupancy, 64'd0);
    check_eq("rst_branch_count", branch_count, 64'd0);
    check_eq("rst_mispredict_count", mispredict_count, 64'd0);
    check_eq("rst_pred_ready", bus.pred_ready, 1'b1);
    check_eq("rst_res_ready", bus.res_ready, 1'b0);
  endtask

  initial begin
    logic [63:0] pc, tgt, rtgt;
    logic rt;
    bus.pred_valid = 1'b0; bus.pred_pc = 64'd0; bus.pred_target = 64'd0;
    bus.res_valid = 1'b0; bus.res_taken = 1'b0; bus.res_target = 64'd0;
    @(posedge clk); #1;
    do_reset();

    // correct not-taken, then taken mispredict
    push(64'h1000, 64'h1004);
    resolve(1'b0, 64'h0);
    push(64'h2000, 64'h2004);
    resolve(1'b1, 64'h2100);

    // fill, overflow attempt, resolve+push at full and at DEPTH-1
    for (int i = 0; i < DEPTH; i++) push(64'h3000 + 64'(i) * 64'h10, 64'h3004 + 64'(i) * 64'h10);
    push(64'h3F00, 64'h3F04);
    step(1'b1, 64'h3100, 64'h3104, 1'b1, 1'b0, 64'd0);
    step(1'b1, 64'h3200, 64'h3204, 1'b1, 1'b0, 64'd0);

    // mispredict with simultaneous push: queue empties and the push is lost
    step(1'b1, 64'h4000, 64'h4004, 1'b1, 1'b1, 64'h9990);
    resolve(1'b0, 64'd0);
    push(64'h5000, 64'h5004);
    resolve(1'b0, 64'd0);

    // pc+4 wraps to zero: not a mispredict
    push(64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    resolve(1'b0, 64'd0);

    // reset while two entries queued and an update pulse is visible
    for (int i = 0; i < 3; i++) push(64'h6000 + 64'(i) * 64'h8, 64'h6004 + 64'(i) * 64'h8);
    resolve(1'b0, 64'd0);
    do_reset();

    // random traffic, also pushes both counters towards saturation
    for (int i = 0; i < 120; i++) begin
      pc  = {32'h0, $urandom() & 32'hFFFF_FFFC};
      tgt = ($urandom_range(0, 1) == 0) ? pc + 64'd4 : pc + 64'h40;
      rt  = 1'($urandom_range(0, 1));
      rtgt = {32'h0, $urandom() & 32'hFFFF_FFFC};
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt   = (mq[0].tgt != mq[0].pc + 64'd4);
        rtgt = mq[0].tgt;
      end
      step(1'($urandom_range(0, 1)), pc, tgt, 1'($urandom_range(0, 1)), rt, rtgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
